bt_pipe_loopback_buf: RTL and testbench

BT_PIPE_LOOPBACK_BUF -- requirements
Module: bt_pipe_loopback_buf

---
 rtl/bt_pipe_pkg.sv | 16 +
 rtl/bt_pipe_loopback_buf_if.sv | 22 ++
 rtl/bt_pipe_ram.sv | 24 ++
 rtl/bt_pipe_loopback_buf.sv | 147 ++++++++++++++
 tb/tb_bt_pipe_loopback_buf.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pipe_pkg.sv
// Shared encodings for the pipe loopback buffer: read-transform modes and status bit positions.
package bt_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_REV   = 2'd1,
    MODE_INV   = 2'd2,
    MODE_BSWAP = 2'd3
  } mode_e;

  localparam int STATUS_W     = 3;
  localparam int ST_OVERFLOW  = 0;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_ALIGN_ERR = 2;

endpackage

// File: rtl/bt_pipe_loopback_buf_if.sv
// Block-throttled pipe pair: host-to-device (in_*) and device-to-host (out_*) endpoints.
interface bt_pipe_loopback_buf_if #(
  parameter int DATA_W = 32
);
  logic              in_write;
  logic [DATA_W-1:0] in_data;
  logic              in_blockstrobe;
  logic              in_ready;
  logic              out_read;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_write, in_data, in_blockstrobe, out_read,
    input  in_ready, out_data, out_ready
  );

  modport slave (
    input  in_write, in_data, in_blockstrobe, out_read,
    output in_ready, out_data, out_ready
  );
endinterface

// File: rtl/bt_pipe_ram.sv
// Simple dual-port storage, DATA_W x DEPTH: synchronous write, asynchronous (combinational) read.
module bt_pipe_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     okClk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge okClk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bt_pipe_loopback_buf.sv
// Circular loopback buffer between two block-throttled pipes; read data is registered (host sees it next cycle).
// Readiness is per block from count; overfull writes are dropped, empty reads return 0, both flagged sticky.
module bt_pipe_loopback_buf #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                   okClk,
  input  logic                   rstn,
  input  logic [1:0]             mode,
  bt_pipe_loopback_buf_if.slave  pipe,
  output logic [$clog2(DEPTH):0] count,
  output logic [2:0]             status,
  output logic [7:0]             led_byte
);
  import bt_pipe_pkg::*;

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int NBYTES = DATA_W / 8;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] BLK_C    = CW'(BLOCK_WORDS);
  localparam logic [AW-1:0] OFS_MASK = AW'(BLOCK_WORDS - 1);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [7:0]          led_q, led_d;
  mode_e               mode_q, mode_d;

  logic              wr_acc, rd_acc, buf_full, buf_empty;
  logic              rd_at_boundary, wr_at_boundary;
  mode_e             eff_mode;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata, xf_word;
  logic [CW-1:0]     free_words;

  assign buf_full  = (count_q == DEPTH_C);
  assign buf_empty = (count_q == '0);
  assign wr_acc    = pipe.in_write && !buf_full;
  assign rd_acc    = pipe.out_read && !buf_empty;

  assign rd_at_boundary = ((rd_ptr_q & OFS_MASK) == '0);
  assign wr_at_boundary = ((wr_ptr_q & OFS_MASK) == '0);

  // The incoming mode governs the first word of a block; later words reuse the latched copy.
  assign eff_mode  = rd_at_boundary ? mode_e'(mode) : mode_q;
  assign ram_raddr = (eff_mode == MODE_REV) ? (rd_ptr_q ^ OFS_MASK) : rd_ptr_q;

  bt_pipe_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .okClk (okClk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (pipe.in_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    xf_word = ram_rdata;
    case (eff_mode)
      MODE_INV: xf_word = ~ram_rdata;
      MODE_BSWAP: begin
        for (int i = 0; i < NBYTES; i++) begin
          xf_word[8*i +: 8] = ram_rdata[DATA_W-8*(i+1) +: 8];
        end
      end
      default: xf_word = ram_rdata;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    status_d   = status_q;
    led_d      = led_q;
    mode_d     = mode_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      led_d    = pipe.in_data[7:0];
    end else if (pipe.in_write) begin
      status_d[ST_OVERFLOW] = 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_data_d = xf_word;
      if (rd_at_boundary) begin
        mode_d = mode_e'(mode);
      end
    end else if (pipe.out_read) begin
      out_data_d              = '0;
      status_d[ST_UNDERFLOW]  = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A reversed block needs the whole block present before its first word can be fetched.
    if ((pipe.in_blockstrobe && !wr_at_boundary) ||
        (pipe.out_read && rd_at_boundary && (eff_mode == MODE_REV) && (count_q < BLK_C))) begin
      status_d[ST_ALIGN_ERR] = 1'b1;
    end
  end

  always_ff @(posedge okClk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      status_q   <= '0;
      led_q      <= '0;
      mode_q     <= MODE_PASS;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      status_q   <= status_d;
      led_q      <= led_d;
      mode_q     <= mode_d;
    end
  end

  assign free_words     = DEPTH_C - count_q;
  assign pipe.in_ready  = (free_words >= BLK_C);
  assign pipe.out_ready = (count_q >= BLK_C);
  assign pipe.out_data  = out_data_q;

  assign count    = count_q;
  assign status   = status_q;
  assign led_byte = led_q;

endmodule

// File: tb/tb_bt_pipe_loopback_buf.sv
// Directed bench for bt_pipe_loopback_buf: a transform vector table plus hand-written multi-cycle sequences.
module tb_bt_pipe_loopback_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int BLK    = 4;

  logic        okClk = 1'b0;
  logic        rstn;
  logic [1:0]  mode_r;
  logic [6:0]  count;
  logic [2:0]  status;
  logic [7:0]  led_byte;

  int checks = 0;
  int errors = 0;

  bt_pipe_loopback_buf_if #(.DATA_W(DATA_W)) pif ();

  bt_pipe_loopback_buf #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .BLOCK_WORDS (BLK)
  ) dut (
    .okClk    (okClk),
    .rstn     (rstn),
    .mode     (mode_r),
    .pipe     (pif),
    .count    (count),
    .status   (status),
    .led_byte (led_byte)
  );

  always #5 okClk = ~okClk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge okClk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] d);
    pif.in_write = 1'b1;
    pif.in_data  = d;
    step();
    pif.in_write = 1'b0;
  endtask

  task automatic do_read(output logic [31:0] d);
    pif.out_read = 1'b1;
    step();
    pif.out_read = 1'b0;
    d = pif.out_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] q[$];
    logic [31:0] exp_rev[8];

    vecs[0] = '{2'd0, 32'hA5A5_1234, 32'hA5A5_1234};
    vecs[1] = '{2'd2, 32'h0000_FFFF, 32'hFFFF_0000};
    vecs[2] = '{2'd3, 32'h1234_5678, 32'h7856_3412};
    vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{2'd3, 32'hAABB_CCDD, 32'hDDCC_BBAA};
    vecs[5] = '{2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    exp_rev = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd8, 32'd7, 32'd6, 32'd5};

    rstn               = 1'b0;
    mode_r             = 2'd0;
    pif.in_write       = 1'b0;
    pif.in_data        = '0;
    pif.in_blockstrobe = 1'b0;
    pif.out_read       = 1'b0;
    step();
    step();
    rstn = 1'b1;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_status", status, 0);
    chk("rst_out_data", pif.out_data, 0);
    chk("rst_led", led_byte, 0);
    chk("rst_in_ready", pif.in_ready, 1);
    chk("rst_out_ready", pif.out_ready, 0);

    // Pass-through block
    for (int i = 0; i < 4; i++) do_write(32'h11 * (i + 1));
    chk("pass_out_ready", pif.out_ready, 1);
    chk("pass_count4", count, 4);
    chk("pass_led", led_byte, 8'h44);
    for (int i = 0; i < 4; i++) begin
      do_read(rd);
      chk("pass_data", rd, 32'h11 * (i + 1));
    end
    chk("pass_count0", count, 0);
    chk("pass_out_ready0", pif.out_ready, 0);

    // Word reverse within blocks
    do_reset();
    mode_r = 2'd1;
    for (int i = 1; i <= 8; i++) do_write(32'(i));
    for (int i = 0; i < 8; i++) begin
      do_read(rd);
      chk("rev_data", rd, exp_rev[i]);
    end
    chk("rev_status", status, 0);

    // Single-word transform table
    foreach (vecs[k]) begin
      do_reset();
      mode_r = vecs[k].mode;
      do_write(vecs[k].wdata);
      chk("vec_led", led_byte, {24'h0, vecs[k].wdata[7:0]});
      do_read(rd);
      chk("vec_data", rd, vecs[k].exp);
      chk("vec_count", count, 0);
      chk("vec_status", status, 0);
    end

    // Fill past full, then drain past empty
    do_reset();
    mode_r = 2'd0;
    for (int i = 0; i < 65; i++) begin
      do_write(32'(100 + i));
      chk("ovf_in_ready", pif.in_ready, (i + 1 <= 60) ? 1 : 0);
      chk("ovf_out_ready", pif.out_ready, (i + 1 >= 4) ? 1 : 0);
    end
    chk("ovf_count", count, 64);
    chk("ovf_status", status, 3'b001);
    chk("ovf_led", led_byte, 8'hA3);
    for (int i = 0; i < 64; i++) begin
      do_read(rd);
      chk("drain_data", rd, 32'(100 + i));
    end
    do_read(rd);
    chk("udf_data", rd, 0);
    chk("udf_status", status, 3'b011);
    chk("udf_count", count, 0);

    // Block strobe at a boundary is legal, mid-block it is not
    do_reset();
    pif.in_blockstrobe = 1'b1;
    step();
    pif.in_blockstrobe = 1'b0;
    chk("strobe_ok_status", status, 0);
    do_write(32'hCAFE_0001);
    do_write(32'hCAFE_0002);
    pif.in_blockstrobe = 1'b1;
    step();
    pif.in_blockstrobe = 1'b0;
    chk("strobe_align_err", status, 3'b100);
    do_read(rd);
    chk("pre_rst_data", rd, 32'hCAFE_0001);

    // Reset mid-block wins over a concurrent write and read
    rstn         = 1'b0;
    pif.in_write = 1'b1;
    pif.in_data  = 32'h9999_9999;
    pif.out_read = 1'b1;
    step();
    rstn         = 1'b1;
    pif.in_write = 1'b0;
    pif.out_read = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_status", status, 0);
    chk("midrst_out_data", pif.out_data, 0);
    chk("midrst_led", led_byte, 0);

    // Reversed read of a partial block
    mode_r = 2'd1;
    do_write(32'h1);
    do_write(32'h2);
    do_read(rd);
    chk("rev_short_align", status[2], 1);

    // Same-cycle write does not satisfy a read on an empty buffer
    do_reset();
    mode_r       = 2'd0;
    pif.in_write = 1'b1;
    pif.in_data  = 32'h55;
    pif.out_read = 1'b1;
    step();
    chk("simul_empty_data", pif.out_data, 0);
    chk("simul_empty_status", status, 3'b010);
    chk("simul_empty_count", count, 1);
    pif.in_data = 32'h66;
    step();
    pif.in_write = 1'b0;
    pif.out_read = 1'b0;
    chk("simul_data", pif.out_data, 32'h55);
    chk("simul_count", count, 1);

    // Wrap-around streaming with concurrent traffic
    do_reset();
    mode_r = 2'd0;
    q.delete();
    for (int n = 0; n < 10; n++) begin
      do_write(32'(1000 + n));
      q.push_back(32'(1000 + n));
    end
    for (int n = 10; n < 200; n++) begin
      pif.in_write = 1'b1;
      pif.in_data  = 32'(1000 + n);
      pif.out_read = 1'b1;
      step();
      chk("wrap_data", pif.out_data, q.pop_front());
      q.push_back(32'(1000 + n));
      chk("wrap_count", count, 10);
    end
    pif.in_write = 1'b0;
    pif.out_read = 1'b0;
    while (q.size() > 0) begin
      do_read(rd);
      chk("wrap_drain", rd, q.pop_front());
    end
    chk("wrap_final_count", count, 0);
    chk("wrap_status", status, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
